// File: rtl/serial_to_parallel_com_pkg.sv
// Shared constants and FSM encoding for the COM-aligned serial-to-parallel receiver.
package serial_to_parallel_com_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COM_CHAR_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } s2p_state_e;

endpackage

// File: rtl/serial_to_parallel_com.sv
// Bit-serial receiver: locks byte alignment on a run of COM characters, then emits non-COM bytes.
// Optional macro SER2PAR_COM_STATS_EN adds a saturating count of idle COMs seen while ACTIVE.
module serial_to_parallel_com
  import serial_to_parallel_com_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM_CHAR  = COM_CHAR_DEFAULT,
  parameter int                COM_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic              active
`ifdef SER2PAR_COM_STATS_EN
  ,
  output logic [7:0]        com_seen_cnt
`endif
);

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  s2p_state_e state, state_nx;

  // Only the 7 newest history bits are ever observable through cand, so the 8th stage is not kept.
  logic [BYTE_W-2:0] sr;
  logic [2:0]        bit_cnt, bit_cnt_nx;
  logic [3:0]        com_cnt, com_cnt_nx;
  logic [BYTE_W-1:0] data_nx;
  logic              valid_nx;
  logic              strobe_nx;

  logic [BYTE_W-1:0] cand;
  logic              cand_com;
  logic              boundary;

  assign cand     = {sr, data_in};
  assign cand_com = (cand == COM_CHAR);
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    com_cnt_nx = com_cnt;
    data_nx    = data_out;
    valid_nx   = valid_out;
    strobe_nx  = 1'b0;

    case (state)
      SEARCH: begin
        if (cand_com) begin
          bit_cnt_nx = 3'd0;
          com_cnt_nx = 4'd1;
          state_nx   = (COM_TARGET == 4'd1) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          if (cand_com) begin
            com_cnt_nx = com_cnt + 4'd1;
            if ((com_cnt + 4'd1) == COM_TARGET) begin
              state_nx = ACTIVE;
            end
          end else begin
            com_cnt_nx = 4'd0;
            state_nx   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        // COM after lock is idle fill: it clears valid but leaves the last data byte visible.
        if (boundary) begin
          strobe_nx = 1'b1;
          if (cand_com) begin
            valid_nx = 1'b0;
          end else begin
            data_nx  = cand;
            valid_nx = 1'b1;
          end
        end
      end

      default: begin
        state_nx   = SEARCH;
        bit_cnt_nx = 3'd0;
        com_cnt_nx = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr          <= '0;
      bit_cnt     <= 3'd0;
      com_cnt     <= 4'd0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      sr          <= cand[BYTE_W-2:0];
      bit_cnt     <= bit_cnt_nx;
      com_cnt     <= com_cnt_nx;
      data_out    <= data_nx;
      valid_out   <= valid_nx;
      byte_strobe <= strobe_nx;
      active      <= (state_nx == ACTIVE);
    end
  end

`ifdef SER2PAR_COM_STATS_EN
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      com_seen_cnt <= 8'd0;
    end else if ((state == ACTIVE) && boundary && cand_com && (com_seen_cnt != 8'hFF)) begin
      com_seen_cnt <= com_seen_cnt + 8'd1;
    end
  end
`endif

endmodule
